// File: rtl/mips_pkg.sv
// Shared opcode constants and the fetch-state encoding for the instruction front end.
package mips_pkg;
  localparam logic [5:0] OPC_RTYPE  = 6'h00;
  localparam logic [5:0] OPC_ADDI   = 6'h08;
  localparam logic [5:0] OPC_LW     = 6'h23;
  localparam logic [5:0] OPC_SW     = 6'h2B;
  localparam logic [5:0] OPC_LH     = 6'h21;
  localparam logic [5:0] OPC_LHU    = 6'h25;
  localparam logic [5:0] OPC_BEQ    = 6'h04;
  localparam logic [5:0] OPC_BUBBLE = 6'h3F;

  typedef enum logic [1:0] {
    REQ_IDLE,
    REQ,
    ISSUE
  } fetch_state_t;
endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC: pc+4, or pc+4 plus the sign-extended word offset when a branch is taken.
// All arithmetic wraps modulo 2^PC_W.
module pc_next_calc #(
  parameter int PC_W = 32
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic            branch_taken_i,
  input  logic [15:0]     branch_offset_i,
  output logic [PC_W-1:0] pc_plus4_o,
  output logic [PC_W-1:0] pc_next_o
);
  logic [PC_W-1:0] br_disp;

  // Sign-extend first, then scale the word offset to bytes.
  assign br_disp    = {{(PC_W-18){branch_offset_i[15]}}, branch_offset_i, 2'b00};
  assign pc_plus4_o = pc_i + PC_W'(4);
  assign pc_next_o  = branch_taken_i ? (pc_plus4_o + br_disp) : pc_plus4_o;
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: req/ack fetch from imem, holds one instruction for decode, applies taken branches.
// Optional ack-wait timeout with sticky fetch_err is built when IMEM_TIMEOUT_EN is defined.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter int              PC_W        = 32,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter int              TIMEOUT_CYC = 16
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [15:0]     branch_offset,
  output logic [31:0]     instr,
  output logic            instr_valid,
  output logic [5:0]      next_opCode,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus4,
  output logic            fetch_err
);
  localparam logic [PC_W-1:0] RESET_PC_W = {RESET_PC[PC_W-1:2], 2'b00};

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_next;
  logic [31:0]     instr_q;
  logic            timeout_hit;

  pc_next_calc #(.PC_W(PC_W)) u_pc_next (
    .pc_i            (pc_q),
    .branch_taken_i  (branch_taken),
    .branch_offset_i (branch_offset),
    .pc_plus4_o      (pc_plus4),
    .pc_next_o       (pc_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= REQ_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      REQ_IDLE: state_d = REQ;
      REQ: begin
        if (imem_ack)         state_d = ISSUE;
        else if (timeout_hit) state_d = REQ_IDLE;
      end
      ISSUE:    if (!stall) state_d = REQ;
      default:  state_d = REQ_IDLE;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    imem_addr   = '0;
    instr_valid = 1'b0;
    case (state_q)
      REQ: begin
        imem_req  = 1'b1;
        imem_addr = pc_q;
      end
      ISSUE:   instr_valid = 1'b1;
      default: ;
    endcase
  end

  // Branch is only consumed on the cycle the held instruction actually leaves ISSUE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= RESET_PC_W;
      instr_q <= '0;
    end else begin
      if (state_q == REQ && imem_ack) instr_q <= imem_rdata;
      if (state_q == ISSUE && !stall) pc_q    <= pc_next;
    end
  end

  assign instr       = instr_q;
  assign pc          = pc_q;
  assign next_opCode = instr_valid ? instr_q[31:26] : OPC_BUBBLE;

`ifdef IMEM_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);

  logic [WAIT_W-1:0] wait_q;
  logic              err_q;

  assign timeout_hit = (state_q == REQ) && !imem_ack && (wait_q == WAIT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_q != REQ || imem_ack || timeout_hit) wait_q <= '0;
      else                                           wait_q <= wait_q + 1'b1;
      if (timeout_hit) err_q <= 1'b1;
    end
  end

  assign fetch_err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign fetch_err   = 1'b0;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: an imem responder serves requests and a scoreboard of expected fetch addresses.
// A second instance with RESET_PC=0xFFFF_FFFC runs in lockstep to cover PC wrap.
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        stall, branch_taken;
  logic [15:0] branch_offset;
  logic [31:0] instr, pc, pc_plus4;
  logic        instr_valid, fetch_err;
  logic [5:0]  next_opCode;

  logic        w_imem_req, w_instr_valid, w_fetch_err;
  logic [31:0] w_imem_addr, w_instr, w_pc, w_pc_plus4;
  logic [5:0]  w_next_opCode;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_pc, last_data, w_addr_seen;
  int          wait_seen;

  always #5 clk = ~clk;

  instr_fetch_unit #(.PC_W(32), .RESET_PC(32'h0000_0000), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
    .branch_taken(branch_taken), .branch_offset(branch_offset), .instr(instr),
    .instr_valid(instr_valid), .next_opCode(next_opCode), .pc(pc),
    .pc_plus4(pc_plus4), .fetch_err(fetch_err)
  );

  instr_fetch_unit #(.PC_W(32), .RESET_PC(32'hFFFF_FFFC), .TIMEOUT_CYC(16)) dut_w (
    .clk(clk), .reset(reset), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
    .branch_taken(branch_taken), .branch_offset(branch_offset), .instr(w_instr),
    .instr_valid(w_instr_valid), .next_opCode(w_next_opCode), .pc(w_pc),
    .pc_plus4(w_pc_plus4), .fetch_err(w_fetch_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance to the next negedge with imem_req high and compare its address with the scoreboard.
  task automatic wait_req();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!imem_req && n < 50);
    wait_seen   = n;
    w_addr_seen = w_imem_addr;
    check_eq("req_seen", {31'b0, imem_req}, 32'd1);
    check_eq("req_valid_low", {31'b0, instr_valid}, 32'd0);
    check_eq("req_opc_bubble", {26'b0, next_opCode}, 32'h3F);
    if (exp_q.size() == 0) check_eq("sb_empty", exp_q.size(), 32'd1);
    else                   check_eq("imem_addr", imem_addr, exp_q.pop_front());
  endtask

  task automatic serve(input int lat, input logic [31:0] data);
    logic [31:0] a;
    wait_req();
    a = imem_addr;
    repeat (lat) @(negedge clk);
    if (lat > 0) check_eq("addr_hold", imem_addr, a);
    imem_ack   = 1'b1;
    imem_rdata = data;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = '0;
    last_data  = data;
    check_eq("issue_valid", {31'b0, instr_valid}, 32'd1);
    check_eq("issue_instr", instr, data);
    check_eq("issue_opc", {26'b0, next_opCode}, {26'b0, data[31:26]});
    check_eq("issue_req_low", {31'b0, imem_req}, 32'd0);
  endtask

  // Called at a negedge in ISSUE. During a stall a taken branch and a stray ack are both presented
  // and must be ignored.
  task automatic issue(input int n_stall, input logic br, input logic [15:0] off);
    check_eq("issue_pc", pc, model_pc);
    check_eq("issue_pc4", pc_plus4, model_pc + 32'd4);
    if (n_stall > 0) begin
      stall         = 1'b1;
      branch_taken  = 1'b1;
      branch_offset = 16'h7FFF;
      imem_ack      = 1'b1;
      imem_rdata    = 32'hFFFF_FFFF;
      repeat (n_stall) begin
        @(negedge clk);
        check_eq("stall_valid", {31'b0, instr_valid}, 32'd1);
        check_eq("stall_req", {31'b0, imem_req}, 32'd0);
        check_eq("stall_instr", instr, last_data);
        check_eq("stall_pc", pc, model_pc);
      end
      imem_ack   = 1'b0;
      imem_rdata = '0;
    end
    stall         = 1'b0;
    branch_taken  = br;
    branch_offset = off;
    model_pc = br ? model_pc + 32'd4 + {{14{off[15]}}, off, 2'b00} : model_pc + 32'd4;
    exp_q.push_back(model_pc);
    @(posedge clk);
    #1;
    branch_taken  = 1'b0;
    branch_offset = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    stall = 1'b0; branch_taken = 1'b0; branch_offset = '0;
    model_pc = 32'h0; last_data = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_req", {31'b0, imem_req}, 32'd0);
    check_eq("rst_addr", imem_addr, 32'h0);
    check_eq("rst_instr", instr, 32'h0);
    check_eq("rst_valid", {31'b0, instr_valid}, 32'd0);
    check_eq("rst_opc", {26'b0, next_opCode}, 32'h3F);
    check_eq("rst_err", {31'b0, fetch_err}, 32'd0);
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_pc_wrap", w_pc, 32'hFFFF_FFFC);
    reset = 1'b1;

    // Sequential fetch with zero-latency ack; lockstep instance wraps.
    exp_q.push_back(32'h0);
    serve(0, 32'h8C08_0004);
    check_eq("wrap_first", w_addr_seen, 32'hFFFF_FFFC);
    issue(0, 1'b0, 16'h0);
    serve(0, 32'h8C08_0004);
    check_eq("gap", wait_seen, 32'd1);
    check_eq("wrap_second", w_addr_seen, 32'h0);
    issue(0, 1'b0, 16'h0);
    serve(0, 32'h1000_0001);
    issue(0, 1'b1, 16'h0001);
    serve(1, 32'h1000_FFFC);
    issue(0, 1'b1, 16'hFFFC);
    serve(2, 32'h2000_0000);
    issue(0, 1'b1, 16'hFFFE);
    serve(0, 32'h1000_0003);
    issue(0, 1'b1, 16'h0003);
    serve(3, 32'h0000_0020);
    issue(3, 1'b0, 16'h0);
    serve(0, 32'hAC00_0000);

    // Reset in the middle of an ack wait; an ack right after release must not be taken.
    issue(0, 1'b0, 16'h0);
    wait_req();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("mid_rst_req", {31'b0, imem_req}, 32'd0);
    check_eq("mid_rst_pc", pc, 32'h0);
    check_eq("mid_rst_opc", {26'b0, next_opCode}, 32'h3F);
    @(negedge clk);
    reset      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    model_pc   = 32'h0;
    exp_q.delete();
    exp_q.push_back(32'h0);
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = '0;
    check_eq("late_ack_valid", {31'b0, instr_valid}, 32'd0);
    check_eq("late_ack_instr", instr, 32'h0);
    serve(1, 32'h2108_0005);

`ifdef IMEM_TIMEOUT_EN
    issue(0, 1'b0, 16'h0);
    wait_req();
    k = 0;
    while (imem_req && k < 40) begin
      k++;
      @(negedge clk);
    end
    check_eq("to_cycles", k, 32'd16);
    check_eq("to_err", {31'b0, fetch_err}, 32'd1);
    check_eq("to_opc", {26'b0, next_opCode}, 32'h3F);
    exp_q.push_back(model_pc);
    serve(0, 32'h8C08_0008);
    check_eq("to_err_sticky", {31'b0, fetch_err}, 32'd1);
`else
    issue(0, 1'b0, 16'h0);
    k = 0;
    serve(20, 32'h8C08_0008);
    check_eq("no_err", {31'b0, fetch_err}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
